// File: rtl/digit_serial_adder_if.sv
// digit_serial_adder_if: operand, mode and result bundle for the digit-serial adder
interface digit_serial_adder_if #(parameter int WIDTH = 16);
  logic             start_i, sub_i, C_i, busy_o, done_o, C_o, V_o;
  logic [WIDTH-1:0] A_i, B_i, S_o;
  modport master (output start_i, sub_i, A_i, B_i, C_i, input busy_o, done_o, S_o, C_o, V_o);
  modport slave  (input start_i, sub_i, A_i, B_i, C_i, output busy_o, done_o, S_o, C_o, V_o);
endinterface

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/subtract, DIGIT bits per clock LSB first through a registered carry
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                 clk_i,
  input logic                 rst_i,
  digit_serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("digit_serial_adder: illegal WIDTH/DIGIT combination");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, w_a_nx;
  logic             r_c, w_last, w_start;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT:0]   w_dsum;
  logic [DIGIT-1:0] w_cv;
  assign w_dsum  = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
  // carries into each bit of the digit; the top one is the carry into the word MSB on the last digit
  assign w_cv    = r_a[DIGIT-1:0] ^ r_b[DIGIT-1:0] ^ w_dsum[DIGIT-1:0];
  // sum digits shift into the top of r_a as operand digits shift out of the bottom
  assign w_a_nx  = WIDTH'({w_dsum[DIGIT-1:0], r_a} >> DIGIT);
  assign w_last  = r_cnt == CW'(N - 1);
  assign w_start = bus.start_i && r_state != RUN;
  assign bus.busy_o = r_state == RUN;
  assign bus.done_o = r_state == DONE;
  always_comb begin
    w_next = r_state == RUN ? (w_last ? DONE : RUN) : (bus.start_i ? RUN : IDLE);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      bus.S_o <= '0;
      bus.C_o <= 1'b0;
      bus.V_o <= 1'b0;
    end else if (w_start) begin
      r_a   <= bus.A_i;
      r_b   <= bus.sub_i ? ~bus.B_i : bus.B_i;
      r_c   <= bus.sub_i ^ bus.C_i;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= w_a_nx;
      r_b   <= r_b >> DIGIT;
      r_c   <= w_dsum[DIGIT];
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        bus.S_o <= w_a_nx;
        bus.C_o <= w_dsum[DIGIT];
        bus.V_o <= w_dsum[DIGIT] ^ w_cv[DIGIT-1];
      end
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed and randomized checks of digit_serial_adder against an arithmetic model
module tb_digit_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;

  digit_serial_adder_if #(16) bus  ();
  digit_serial_adder_if #(16) if_a ();
  digit_serial_adder_if #(16) if_b ();
  digit_serial_adder_if #(8)  if_c ();
  digit_serial_adder_if #(1)  if_d ();

  digit_serial_adder #(.WIDTH(16), .DIGIT(4))  dut   (.clk_i(clk), .rst_i(rst), .bus(bus));
  digit_serial_adder #(.WIDTH(16), .DIGIT(1))  dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b));
  digit_serial_adder #(.WIDTH(8),  .DIGIT(2))  dut_c (.clk_i(clk), .rst_i(rst), .bus(if_c));
  digit_serial_adder #(.WIDTH(1),  .DIGIT(1))  dut_d (.clk_i(clk), .rst_i(rst), .bus(if_d));

  // {V, C, S} of (A + B' + cin) mod 2^w, from plain integer arithmetic
  function automatic logic [17:0] model(int w, logic [15:0] a, logic [15:0] b, logic c, logic s);
    longint mask, aa, bb, sum;
    logic   co, v;
    mask = (longint'(1) << w) - 1;
    aa   = longint'(a) & mask;
    bb   = (s ? longint'(~b) : longint'(b)) & mask;
    sum  = aa + bb + longint'(s ? !c : c);
    co   = ((sum >> w) & 1) != 0;
    v    = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    return {v, co, 16'(sum & mask)};
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                        input logic poke, output int lat, output int busy_n, output logic stable);
    logic [15:0] s0;
    s0 = bus.S_o;
    bus.A_i = a; bus.B_i = b; bus.C_i = c; bus.sub_i = s; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.A_i = 16'($urandom); bus.B_i = 16'($urandom); bus.C_i = 1'($urandom); bus.sub_i = 1'($urandom);
    lat = 1; busy_n = 0; stable = 1'b1;
    while (!bus.done_o && lat < 40) begin
      if (bus.S_o !== s0) stable = 1'b0;
      if (bus.busy_o) busy_n++;
      bus.start_i = poke && lat == 2;
      @(posedge clk); #1;
      lat++;
    end
    bus.start_i = 1'b0;
    if (!bus.done_o) lat = -1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy_o, bus.done_o, bus.V_o, bus.C_o, bus.S_o} !== 19'h0) begin
      errors++; $display("FAIL reset_async got %h want 0", {bus.busy_o, bus.done_o, bus.V_o, bus.C_o, bus.S_o});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy_o, bus.done_o, bus.V_o, bus.C_o, bus.S_o} !== 19'h0) begin
      errors++; $display("FAIL reset_held got %h want 0", {bus.busy_o, bus.done_o, bus.V_o, bus.C_o, bus.S_o});
    end
    rst = 1'b0;
  endtask

  task automatic test_add;
    logic [15:0] ta [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
    logic [15:0] tb [3] = '{16'h4321, 16'h0001, 16'h0001};
    logic [17:0] ex [3] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b10, 16'h8000}};
    int lat, bn;
    logic st;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      run_op(ta[i], tb[i], 1'b0, 1'b0, 1'b0, lat, bn, st);
      checks++; if (lat !== 5) begin errors++; $display("FAIL add%0d_latency got %0d want 5", i, lat); end
      checks++; if (bn !== 4) begin errors++; $display("FAIL add%0d_busy_cycles got %0d want 4", i, bn); end
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL add%0d_S_held_during_busy got changed want held", i); end
      checks++;
      if ({bus.V_o, bus.C_o, bus.S_o} !== ex[i]) begin
        errors++; $display("FAIL add%0d_result got %h want %h", i, {bus.V_o, bus.C_o, bus.S_o}, ex[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.done_o, bus.busy_o} !== 2'b00) begin
      errors++; $display("FAIL done_single_pulse got done/busy %b want 00", {bus.done_o, bus.busy_o});
    end
  endtask

  task automatic test_sub;
    logic [15:0] ta [3] = '{16'h0005, 16'h0007, 16'h8000};
    logic [15:0] tb [3] = '{16'h0007, 16'h0005, 16'h0001};
    logic        tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [17:0] ex [3] = '{{2'b00, 16'hFFFE}, {2'b01, 16'h0001}, {2'b11, 16'h7FFF}};
    int lat, bn;
    logic st;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      run_op(ta[i], tb[i], tc[i], 1'b1, 1'b0, lat, bn, st);
      checks++; if (lat !== 5) begin errors++; $display("FAIL sub%0d_latency got %0d want 5", i, lat); end
      checks++;
      if ({bus.V_o, bus.C_o, bus.S_o} !== ex[i]) begin
        errors++; $display("FAIL sub%0d_result got %h want %h", i, {bus.V_o, bus.C_o, bus.S_o}, ex[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat, bn;
    logic st;
    @(posedge clk); #1;
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, lat, bn, st);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ignore_latency got %0d want 5", lat); end
    checks++;
    if ({bus.V_o, bus.C_o, bus.S_o} !== {2'b00, 16'h3333}) begin
      errors++; $display("FAIL ignore_result got %h want 03333", {bus.V_o, bus.C_o, bus.S_o});
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.busy_o, bus.done_o} !== 2'b00) begin
      errors++; $display("FAIL ignore_no_restart got busy/done %b want 00", {bus.busy_o, bus.done_o});
    end
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    logic st;
    for (int i = 0; i < 20; i++) begin
      logic [15:0] a1, b1, a2, b2;
      logic c1, s1, c2, s2;
      a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom); s1 = 1'($urandom);
      a2 = 16'($urandom); b2 = 16'($urandom); c2 = 1'($urandom); s2 = 1'($urandom);
      @(posedge clk); #1;
      run_op(a1, b1, c1, s1, 1'b0, lat, bn, st);
      checks++;
      if (lat !== 5 || {bus.V_o, bus.C_o, bus.S_o} !== model(16, a1, b1, c1, s1)) begin
        errors++; $display("FAIL b2b_first got lat %0d res %h want lat 5 res %h", lat, {bus.V_o, bus.C_o, bus.S_o}, model(16, a1, b1, c1, s1));
      end
      run_op(a2, b2, c2, s2, 1'b0, lat, bn, st);
      checks++;
      if (lat !== 5 || {bus.V_o, bus.C_o, bus.S_o} !== model(16, a2, b2, c2, s2)) begin
        errors++; $display("FAIL b2b_second got lat %0d res %h want lat 5 res %h", lat, {bus.V_o, bus.C_o, bus.S_o}, model(16, a2, b2, c2, s2));
      end
    end
  endtask

  task automatic test_async_reset;
    int lat, bn, seen;
    logic st;
    @(posedge clk); #1;
    run_op(16'h0F0F, 16'h1010, 1'b1, 1'b0, 1'b0, lat, bn, st);
    checks++;
    if ({bus.V_o, bus.C_o, bus.S_o} !== {2'b00, 16'h1F20}) begin
      errors++; $display("FAIL arst_pre_result got %h want 01f20", {bus.V_o, bus.C_o, bus.S_o});
    end
    @(posedge clk); #1;
    bus.A_i = 16'hAAAA; bus.B_i = 16'h5555; bus.C_i = 1'b0; bus.sub_i = 1'b0; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy_o, bus.done_o, bus.V_o, bus.C_o, bus.S_o} !== 19'h0) begin
      errors++; $display("FAIL arst_mid_run got %h want 0", {bus.busy_o, bus.done_o, bus.V_o, bus.C_o, bus.S_o});
    end
    #1 rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done_o || bus.busy_o) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL arst_no_done got %0d active cycles want 0", seen); end
    run_op(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0, lat, bn, st);
    checks++;
    if (lat !== 5 || {bus.V_o, bus.C_o, bus.S_o} !== {2'b10, 16'h8000}) begin
      errors++; $display("FAIL arst_recover got lat %0d res %h want lat 5 res 28000", lat, {bus.V_o, bus.C_o, bus.S_o});
    end
  endtask

  task automatic test_sweep;
    int w [4] = '{16, 16, 8, 1};
    int d [4] = '{1, 16, 2, 1};
    for (int it = 0; it < 1000; it++) begin
      logic [15:0] a, b;
      logic c, s;
      int lt [4];
      logic [17:0] got [4];
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
      if_a.A_i = a;      if_a.B_i = b;      if_a.C_i = c; if_a.sub_i = s; if_a.start_i = 1'b1;
      if_b.A_i = a;      if_b.B_i = b;      if_b.C_i = c; if_b.sub_i = s; if_b.start_i = 1'b1;
      if_c.A_i = a[7:0]; if_c.B_i = b[7:0]; if_c.C_i = c; if_c.sub_i = s; if_c.start_i = 1'b1;
      if_d.A_i = a[0];   if_d.B_i = b[0];   if_d.C_i = c; if_d.sub_i = s; if_d.start_i = 1'b1;
      @(posedge clk); #1;
      if_a.start_i = 1'b0; if_b.start_i = 1'b0; if_c.start_i = 1'b0; if_d.start_i = 1'b0;
      lt = '{-1, -1, -1, -1};
      for (int lat = 1; lat <= 18; lat++) begin
        if (if_a.done_o && lt[0] < 0) begin lt[0] = lat; got[0] = {if_a.V_o, if_a.C_o, if_a.S_o}; end
        if (if_b.done_o && lt[1] < 0) begin lt[1] = lat; got[1] = {if_b.V_o, if_b.C_o, if_b.S_o}; end
        if (if_c.done_o && lt[2] < 0) begin lt[2] = lat; got[2] = {if_c.V_o, if_c.C_o, 8'h00, if_c.S_o}; end
        if (if_d.done_o && lt[3] < 0) begin lt[3] = lat; got[3] = {if_d.V_o, if_d.C_o, 15'h0, if_d.S_o}; end
        @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (lt[i] !== w[i] / d[i] + 1) begin
          errors++; $display("FAIL sweep_latency w%0d_d%0d got %0d want %0d", w[i], d[i], lt[i], w[i] / d[i] + 1);
        end
        checks++;
        if (got[i] !== model(w[i], a, b, c, s)) begin
          errors++; $display("FAIL sweep_result w%0d_d%0d a=%h b=%h c=%b sub=%b got %h want %h", w[i], d[i], a, b, c, s, got[i], model(w[i], a, b, c, s));
        end
      end
    end
  endtask

  initial begin
    bus.start_i = 1'b0;  bus.sub_i = 1'b0;  bus.C_i = 1'b0;  bus.A_i = '0;  bus.B_i = '0;
    if_a.start_i = 1'b0; if_a.sub_i = 1'b0; if_a.C_i = 1'b0; if_a.A_i = '0; if_a.B_i = '0;
    if_b.start_i = 1'b0; if_b.sub_i = 1'b0; if_b.C_i = 1'b0; if_b.A_i = '0; if_b.B_i = '0;
    if_c.start_i = 1'b0; if_c.sub_i = 1'b0; if_c.C_i = 1'b0; if_c.A_i = '0; if_c.B_i = '0;
    if_d.start_i = 1'b0; if_d.sub_i = 1'b0; if_d.C_i = 1'b0; if_d.A_i = '0; if_d.B_i = '0;
    test_reset;
    test_add;
    test_sub;
    test_ignore_start;
    test_back_to_back;
    test_async_reset;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
